serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and parameter checks for serial_adder.
// Optional overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

  function automatic bit width_ok(int w);
    return (w >= 1) && (w <= 32);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial datapath slice.
// Purely combinational.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  import serial_adder_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (WIDTH > 1) ? WIDTH - 1 : 1;

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_adder: WIDTH must be in 1..32");
    end
  endgenerate

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [RW-1:0]    res_sh;
  logic [RW-1:0]    res_sh_nx;
  logic [WIDTH-1:0] res_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last;

  full_adder u_fa (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .Cin (carry),
    .Sum (fa_s),
    .Cout(fa_c)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // Only the upper WIDTH-1 result bits need storage; the
  // newest bit comes straight from the adder on the last edge.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nx    = fa_s;
      assign res_sh_nx = res_sh;
    end else begin : g_wn
      assign res_nx    = {fa_s, res_sh};
      assign res_sh_nx = res_nx[WIDTH-1:1];
    end
  endgenerate

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_SHIFT;
      S_SHIFT: if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_sh_nx;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum  <= res_nx;
            cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= carry ^ fa_c;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 4 and 1.
// Reference results come from plain integer arithmetic.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st8, c8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       st4, c4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       st1, c1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4, ovf1;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8),
    .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4),
    .a(a4), .b(b4), .cin(c4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1),
    .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int w);
    case (w)
      8:       return done8;
      4:       return done4;
      default: return done1;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      8:       return busy8;
      4:       return busy4;
      default: return busy1;
    endcase
  endfunction

  function automatic logic [8:0] get_res(input int w);
    case (w)
      8:       return {cout8, sum8};
      4:       return {4'b0, cout4, sum4};
      default: return {7'b0, cout1, sum1};
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    case (w)
      8: begin st8 = s; a8 = a; b8 = b; c8 = c; end
      4: begin st4 = s; a4 = a[3:0]; b4 = b[3:0]; c4 = c; end
      default: begin st1 = s; a1 = a[0]; b1 = b[0]; c1 = c; end
    endcase
  endtask

  // One full transaction from IDLE, checked against a + b + cin.
  task automatic run(input int w, input logic [7:0] a,
                     input logic [7:0] b, input logic c,
                     input string tag);
    int exp;
    int n;
    int bz;
    logic [7:0] junk_a;
    logic [7:0] junk_b;
    exp = int'(a) + int'(b) + int'(c);
    drive(w, 1'b1, a, b, c);
    tick();
    junk_a = 8'($urandom);
    junk_b = 8'($urandom);
    drive(w, 1'b0, junk_a, junk_b, junk_a[0]);
    n = 0;
    bz = 0;
    while (!get_done(w) && n < 40) begin
      if (get_busy(w)) bz++;
      tick();
      n++;
    end
    if (get_busy(w)) bz++;
    chk({tag, "_latency"}, 64'(n), 64'(w));
    chk({tag, "_busy_cycles"}, 64'(bz), 64'(w + 1));
    chk({tag, "_result"}, 64'(get_res(w)), 64'(exp));
`ifdef SERIAL_ADDER_OVF_EN
    if (w == 8) begin
      int sa;
      int sb;
      int s;
      sa = a[7] ? int'(a) - 256 : int'(a);
      sb = b[7] ? int'(b) - 256 : int'(b);
      s = sa + sb + int'(c);
      chk({tag, "_ovf"}, 64'(ovf8), 64'((s > 127) || (s < -128)));
    end
`endif
    tick();
    chk({tag, "_done_pulse"}, 64'(get_done(w)), 64'(0));
    chk({tag, "_idle"}, 64'(get_busy(w)), 64'(0));
  endtask

  initial begin
    int nd;
    logic [7:0] ra;
    logic [7:0] rb;
    drive(8, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(1, 1'b0, 8'h0, 8'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy8), 64'(0));
    chk("rst_done", 64'(done8), 64'(0));
    chk("rst_sum", 64'(sum8), 64'(0));
    chk("rst_cout", 64'(cout8), 64'(0));
    chk("rst_res4", 64'({cout4, sum4}), 64'(0));
    chk("rst_res1", 64'({cout1, sum1}), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 64'(ovf8), 64'(0));
`endif
    rst_n = 1'b1;
    tick();

    run(8, 8'h0F, 8'h01, 1'b0, "t1");
    run(8, 8'hFF, 8'h01, 1'b0, "t2a");
    run(8, 8'hFF, 8'hFF, 1'b1, "t2b");

    // start held high: second add is accepted only after DONE->IDLE
    drive(8, 1'b1, 8'h12, 8'h34, 1'b0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin
        a8 = 8'hAA;
        b8 = 8'h55;
      end
      if (done8) nd++;
      if (i == 8) chk("t3_first", 64'({cout8, sum8}), 64'(9'h046));
      if (i == 9) chk("t3_idle_gap", 64'(busy8), 64'(0));
      if (i == 10) chk("t3_reaccept", 64'(busy8), 64'(1));
      if (i == 18) chk("t3_second", 64'({cout8, sum8}), 64'(9'h0FF));
    end
    chk("t3_done_count", 64'(nd), 64'(2));
    st8 = 1'b0;
    tick();
    chk("t3_end_idle", 64'(busy8), 64'(0));

    // reset during the 4th SHIFT cycle abandons the add
    drive(8, 1'b1, 8'h3C, 8'h5A, 1'b1);
    tick();
    st8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_busy", 64'(busy8), 64'(0));
    chk("t4_done", 64'(done8), 64'(0));
    chk("t4_sum", 64'(sum8), 64'(0));
    chk("t4_cout", 64'(cout8), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
    chk("t4_ovf", 64'(ovf8), 64'(0));
`endif
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) nd++;
    end
    chk("t4_no_done", 64'(nd), 64'(0));
    run(8, 8'h80, 8'h80, 1'b0, "t4_new");

    run(8, 8'h7F, 8'h01, 1'b0, "t5a");
    run(8, 8'h80, 8'hFF, 1'b0, "t5b");
    run(8, 8'h01, 8'h01, 1'b0, "t5c");

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run(8, ra, rb, 1'($urandom), "rnd8");
    end

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          run(4, 8'(x), 8'(y), 1'(c), "w4");

    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++)
          run(1, 8'(x), 8'(y), 1'(c), "w1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
